// File: rtl/bucket_stream_serializer.sv
// Captures one NUM_FEATURES x M bucket frame on in_done and streams it out over valid/ready.
// Optional BUCKET_ARGMAX_EN appends a per-feature argmax index beat after each feature's buckets.
module bucket_stream_serializer #(
  parameter int PRECISION    = 8,
  parameter int NUM_FEATURES = 1,
  parameter int M            = 6,
  localparam int FW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1,
  localparam int BW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [PRECISION-1:0] in_data [NUM_FEATURES][M],
  input  logic                 in_done,
  output logic [PRECISION-1:0] out_data,
  output logic [FW-1:0]        out_feat,
  output logic [BW-1:0]        out_bucket,
  output logic                 out_is_idx,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [FW-1:0] LAST_F = FW'(NUM_FEATURES - 1);
  localparam logic [BW-1:0] LAST_B = BW'(M - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PRECISION-1:0] r_buf [NUM_FEATURES][M];
  logic [FW-1:0]        r_feat;
  logic [BW-1:0]        r_bucket;
  logic                 r_overrun;

  logic                 w_valid;
  logic                 w_fire;
  logic                 w_last_feat;
  logic                 w_last_bkt;
  logic                 w_last_beat;
  logic                 w_last_fire;
  logic                 w_capture;
  logic                 w_drop;
  logic                 w_is_idx;
  logic [PRECISION-1:0] w_elem;
  logic [PRECISION-1:0] w_beat_data;

`ifdef BUCKET_ARGMAX_EN
  logic                 r_is_idx;
  logic [PRECISION-1:0] r_max;
  logic [BW-1:0]        r_idx;

  if (PRECISION < BW) begin : g_precision_check
    $error("bucket_stream_serializer: PRECISION must be >= BW to carry the argmax index");
  end

  assign w_is_idx    = r_is_idx;
  assign w_last_beat = w_last_feat && r_is_idx;
  assign w_beat_data = r_is_idx ? PRECISION'(r_idx) : w_elem;
`else
  assign w_is_idx    = 1'b0;
  assign w_last_beat = w_last_feat && w_last_bkt;
  assign w_beat_data = w_elem;
`endif

  assign w_valid     = (r_state == S_STREAM);
  assign w_fire      = w_valid && out_ready;
  assign w_last_feat = (r_feat == LAST_F);
  assign w_last_bkt  = (r_bucket == LAST_B);
  assign w_last_fire = w_fire && w_last_beat;
  assign w_elem      = r_buf[r_feat][r_bucket];
  // A new frame is only accepted when idle or exactly as the final beat leaves.
  assign w_capture   = in_done && (!w_valid || w_last_fire);
  assign w_drop      = in_done && w_valid && !w_last_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (in_done) w_state_nxt = S_STREAM;
      S_STREAM: if (w_last_fire && !in_done) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < NUM_FEATURES; f++)
        for (int b = 0; b < M; b++)
          r_buf[f][b] <= '0;
      r_feat    <= '0;
      r_bucket  <= '0;
      r_overrun <= 1'b0;
`ifdef BUCKET_ARGMAX_EN
      r_is_idx  <= 1'b0;
      r_max     <= '0;
      r_idx     <= '0;
`endif
    end else if (clr) begin
      for (int f = 0; f < NUM_FEATURES; f++)
        for (int b = 0; b < M; b++)
          r_buf[f][b] <= '0;
      r_feat    <= '0;
      r_bucket  <= '0;
      r_overrun <= 1'b0;
`ifdef BUCKET_ARGMAX_EN
      r_is_idx  <= 1'b0;
      r_max     <= '0;
      r_idx     <= '0;
`endif
    end else begin
      if (w_drop) r_overrun <= 1'b1;
      if (w_capture) begin
        r_buf    <= in_data;
        r_feat   <= '0;
        r_bucket <= '0;
`ifdef BUCKET_ARGMAX_EN
        r_is_idx <= 1'b0;
`endif
      end else if (w_fire) begin
`ifdef BUCKET_ARGMAX_EN
        if (r_is_idx) begin
          r_is_idx <= 1'b0;
          r_feat   <= w_last_feat ? '0 : r_feat + 1'b1;
        end else begin
          // Strict compare keeps the lowest index on ties; bucket 0 restarts the search.
          if (r_bucket == '0 || w_elem > r_max) begin
            r_max <= w_elem;
            r_idx <= r_bucket;
          end
          if (w_last_bkt) begin
            r_bucket <= '0;
            r_is_idx <= 1'b1;
          end else begin
            r_bucket <= r_bucket + 1'b1;
          end
        end
`else
        if (w_last_bkt) begin
          r_bucket <= '0;
          r_feat   <= w_last_feat ? '0 : r_feat + 1'b1;
        end else begin
          r_bucket <= r_bucket + 1'b1;
        end
`endif
      end
    end
  end

  assign out_valid  = w_valid;
  assign busy       = w_valid;
  assign overrun    = r_overrun;
  assign out_data   = w_valid ? w_beat_data : '0;
  assign out_feat   = w_valid ? r_feat : '0;
  assign out_bucket = w_valid ? r_bucket : '0;
  assign out_is_idx = w_valid && w_is_idx;
  assign out_last   = w_valid && w_last_beat;

endmodule

// File: tb/tb_bucket_stream_serializer.sv
// Bench for bucket_stream_serializer: per-scenario tasks plus a beat scoreboard fed at frame capture.
module tb_bucket_stream_serializer;

  localparam int P  = 8;
  localparam int NF = 2;
  localparam int MB = 3;
  localparam int FW = 1;
  localparam int BW = 2;
  localparam int W  = 1 + 1 + FW + BW + P;
`ifdef BUCKET_ARGMAX_EN
  localparam bit ARG = 1'b1;
`else
  localparam bit ARG = 1'b0;
`endif
  localparam int FRAME_LEN = ARG ? NF * (MB + 1) : NF * MB;

  typedef logic [P-1:0] frame_t [NF][MB];

  logic          clk;
  logic          rst;
  logic          clr;
  frame_t        in_data;
  logic          in_done;
  logic [P-1:0]  out_data;
  logic [FW-1:0] out_feat;
  logic [BW-1:0] out_bucket;
  logic          out_is_idx;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          overrun;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_obs;
  logic [W-1:0] mon_exp;
  int n_checks = 0;
  int n_fail   = 0;
  int beat_cnt = 0;

  bucket_stream_serializer #(.PRECISION(P), .NUM_FEATURES(NF), .M(MB)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_done(in_done),
    .out_data(out_data), .out_feat(out_feat), .out_bucket(out_bucket),
    .out_is_idx(out_is_idx), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .overrun(overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // model: expected beats of one captured frame
  function automatic void push_frame(input frame_t fr);
    logic [P-1:0]  mx;
    logic [BW-1:0] ix;
    logic          lst;
    for (int f = 0; f < NF; f++) begin
      mx = '0;
      ix = '0;
      for (int b = 0; b < MB; b++) begin
        lst = !ARG && (f == NF - 1) && (b == MB - 1);
        exp_q.push_back({1'b0, lst, FW'(f), BW'(b), fr[f][b]});
        if (b == 0 || fr[f][b] > mx) begin
          mx = fr[f][b];
          ix = BW'(b);
        end
      end
      if (ARG) exp_q.push_back({1'b1, (f == NF - 1), FW'(f), BW'(0), P'(ix)});
    end
  endfunction

  // scoreboard: pop on every accepted beat
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_obs = {out_is_idx, out_last, out_feat, out_bucket, out_data};
      n_checks++;
      beat_cnt++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got %h, required no beat", mon_obs);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_obs !== mon_exp) begin
          n_fail++;
          $display("FAIL beat {idx,last,f,b,data}: got %h, required %h", mon_obs, mon_exp);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input frame_t fr, input bit push);
    in_data = fr;
    in_done = 1'b1;
    if (push) push_frame(fr);
    tick();
    in_done = 1'b0;
  endtask

  function automatic frame_t rand_frame();
    frame_t fr;
    for (int f = 0; f < NF; f++)
      for (int b = 0; b < MB; b++)
        fr[f][b] = P'($urandom_range(0, 255));
    return fr;
  endfunction

  task automatic wait_drain(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (busy) begin
      n_fail++;
      $display("FAIL %s_drain_timeout: busy=%0b, required 0", name, busy);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_beats: %0d left, required 0", name, exp_q.size());
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; in_done = 1'b0; out_ready = 1'b0;
    in_data = '{'{8'd0, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd0}};
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid_busy: got %0b/%0b, required 0/0", out_valid, busy);
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_overrun: got %0b, required 0", overrun);
    end
    n_checks++;
    if ({out_is_idx, out_last, out_feat, out_bucket, out_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0",
               {out_is_idx, out_last, out_feat, out_bucket, out_data});
    end
  endtask

  task automatic test_basic();
    frame_t fr = '{'{8'd1, 8'd2, 8'd3}, '{8'd4, 8'd5, 8'd6}};
    out_ready = 1'b1;
    beat_cnt = 0;
    tick();
    send_frame(fr, 1'b1);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_latency: valid=%0b data=%0d busy=%0b, required 1/1/1", out_valid, out_data, busy);
    end
    wait_drain("basic");
    n_checks++;
    if (beat_cnt != FRAME_LEN) begin
      n_fail++;
      $display("FAIL basic_beat_count: got %0d, required %0d", beat_cnt, FRAME_LEN);
    end
  endtask

  task automatic test_backpressure();
    frame_t fr = '{'{8'd1, 8'd2, 8'd3}, '{8'd4, 8'd5, 8'd6}};
    out_ready = 1'b1;
    beat_cnt = 0;
    send_frame(fr, 1'b1);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_feat, out_bucket, out_data, out_last} !== {1'b1, 1'b0, 2'd1, 8'd2, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: v=%0b f=%0d b=%0d d=%0d l=%0b, required 1/0/1/2/0",
                 i, out_valid, out_feat, out_bucket, out_data, out_last);
      end
    end
    tick();
    out_ready = 1'b1;
    wait_drain("backpressure");
    n_checks++;
    if (beat_cnt != FRAME_LEN) begin
      n_fail++;
      $display("FAIL backpressure_beat_count: got %0d, required %0d", beat_cnt, FRAME_LEN);
    end
  endtask

  task automatic test_back_to_back();
    frame_t fa = rand_frame();
    frame_t fb = rand_frame();
    int n = 0;
    out_ready = 1'b1;
    send_frame(fa, 1'b1);
    while (!(out_valid && out_last) && n < 50) begin
      tick();
      n++;
    end
    n_checks++;
    if (!(out_valid && out_last)) begin
      n_fail++;
      $display("FAIL b2b_last_timeout: last=%0b, required 1", out_last);
    end
    send_frame(fb, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({out_valid, busy, out_feat, out_bucket, out_data, overrun} !== {1'b1, 1'b1, 1'b0, 2'd0, fb[0][0], 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_no_bubble: v=%0b busy=%0b f=%0d b=%0d d=%0d ovr=%0b, required 1/1/0/0/%0d/0",
               out_valid, busy, out_feat, out_bucket, out_data, overrun, fb[0][0]);
    end
    wait_drain("b2b");
  endtask

  task automatic test_overrun();
    frame_t fr    = '{'{8'd1, 8'd2, 8'd3}, '{8'd4, 8'd5, 8'd6}};
    frame_t nines = '{'{8'd9, 8'd9, 8'd9}, '{8'd9, 8'd9, 8'd9}};
    int n = 0;
    out_ready = 1'b1;
    send_frame(fr, 1'b1);
    while (!(out_valid && out_feat == 1'b0 && out_bucket == 2'd2 && !out_is_idx) && n < 50) begin
      tick();
      n++;
    end
    send_frame(nines, 1'b0);
    wait_drain("overrun");
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got %0b, required 1", overrun);
    end
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: got %0b, required 1", overrun);
    end
  endtask

  task automatic test_clr();
    frame_t fr = '{'{8'd1, 8'd2, 8'd3}, '{8'd4, 8'd5, 8'd6}};
    frame_t fn = rand_frame();
    int n = 0;
    out_ready = 1'b1;
    send_frame(fr, 1'b1);
    while (!(out_valid && out_feat == 1'b1 && out_bucket == 2'd0 && !out_is_idx) && n < 50) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_q.delete();
    @(negedge clk);
    n_checks++;
    if ({out_valid, busy, overrun} !== 3'b000) begin
      n_fail++;
      $display("FAIL clr_abort: v=%0b busy=%0b ovr=%0b, required 0/0/0", out_valid, busy, overrun);
    end
    tick();
    out_ready = 1'b1;
    send_frame(fn, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_feat, out_bucket, out_data} !== {1'b1, 1'b0, 2'd0, fn[0][0]}) begin
      n_fail++;
      $display("FAIL clr_restart: v=%0b f=%0d b=%0d d=%0d, required 1/0/0/%0d",
               out_valid, out_feat, out_bucket, out_data, fn[0][0]);
    end
    wait_drain("clr");
  endtask

  task automatic test_random_ready();
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      out_ready = ($urandom_range(0, 1) == 1);
      send_frame(rand_frame(), 1'b1);
      while (busy && n < 300) begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
        n++;
      end
      out_ready = 1'b1;
      wait_drain("random");
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL random_overrun: got %0b, required 0", overrun);
    end
  endtask

  task automatic test_argmax_frame();
    frame_t fr = '{'{8'd7, 8'd9, 8'd9}, '{8'd0, 8'd0, 8'd0}};
    out_ready = 1'b1;
    tick();
    beat_cnt = 0;
    send_frame(fr, 1'b1);
    wait_drain("argmax");
    n_checks++;
    if (beat_cnt != FRAME_LEN) begin
      n_fail++;
      $display("FAIL argmax_beat_count: got %0d, required %0d", beat_cnt, FRAME_LEN);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_clr();
    test_random_ready();
    test_argmax_frame();
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
